// File: rtl/writeback_queue_pkg.sv
// Shared definitions for the writeback queue: opcode encoding and the register-write decode.
package writeback_queue_pkg;

    localparam int WBQ_CTRL_W = 6;

    typedef enum logic [WBQ_CTRL_W-1:0] {
        OP_NOP    = 6'd0,
        OP_LW     = 6'd1,
        OP_LW_IMM = 6'd2,
        OP_SW     = 6'd3,
        OP_ADD    = 6'd4,
        OP_SUB    = 6'd5,
        OP_MUL    = 6'd6,
        OP_DIV    = 6'd7,
        OP_AND    = 6'd8,
        OP_OR     = 6'd9,
        OP_NOT    = 6'd10,
        OP_BEQ    = 6'd11,
        OP_JMP    = 6'd12
    } opcode_e;

    // Reused by any stage that must know whether an instruction commits a register write.
    function automatic logic is_wr(input logic [WBQ_CTRL_W-1:0] op,
                                   input logic addr_zero,
                                   input logic r0_writable);
        logic w;
        case (opcode_e'(op))
            OP_LW, OP_LW_IMM, OP_ADD, OP_SUB, OP_MUL,
            OP_DIV, OP_AND, OP_OR, OP_NOT: w = 1'b1;
            default:                       w = 1'b0;
        endcase
        return w & ~(addr_zero & ~r0_writable);
    endfunction

endpackage

// File: rtl/writeback_queue_if.sv
// Handshake, register-file write and forwarding-lookup signals of the writeback queue.
interface writeback_queue_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 4,
    parameter int CTRL_WIDTH     = 6,
    parameter int DEPTH          = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                             in_valid;
    logic                             in_ready;
    logic        [CTRL_WIDTH-1:0]     ctrl_in;
    logic signed [DATA_WIDTH-1:0]     data;
    logic        [REG_ADDR_WIDTH-1:0] addr;
    logic                             rf_ready;
    logic                             en_out;
    logic signed [DATA_WIDTH-1:0]     data_out;
    logic        [REG_ADDR_WIDTH-1:0] addr_out;
    logic        [REG_ADDR_WIDTH-1:0] fwd_addr;
    logic                             fwd_hit;
    logic signed [DATA_WIDTH-1:0]     fwd_data;
    logic        [CW-1:0]             count;

    modport slave (
        input  in_valid, ctrl_in, data, addr, rf_ready, fwd_addr,
        output in_ready, en_out, data_out, addr_out, fwd_hit, fwd_data, count
    );

    modport master (
        output in_valid, ctrl_in, data, addr, rf_ready, fwd_addr,
        input  in_ready, en_out, data_out, addr_out, fwd_hit, fwd_data, count
    );

endinterface

// File: rtl/writeback_queue_wb_fifo_mem.sv
// Storage array with read/write pointers, occupancy count and newest-first forwarding scan.
module wb_fifo_mem #(
    parameter int  DATA_WIDTH     = 32,
    parameter int  REG_ADDR_WIDTH = 4,
    parameter int  DEPTH          = 4,
    localparam int PW             = $clog2(DEPTH),
    localparam int CW             = PW + 1
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             push_i,
    input  logic                             pop_i,
    input  logic signed [DATA_WIDTH-1:0]     wdata_i,
    input  logic        [REG_ADDR_WIDTH-1:0] waddr_i,
    output logic signed [DATA_WIDTH-1:0]     rdata_o,
    output logic        [REG_ADDR_WIDTH-1:0] raddr_o,
    output logic        [CW-1:0]             count_o,
    input  logic        [REG_ADDR_WIDTH-1:0] fwd_addr_i,
    output logic                             fwd_hit_o,
    output logic signed [DATA_WIDTH-1:0]     fwd_data_o
);

    logic signed [DATA_WIDTH-1:0]     data_q [DEPTH];
    logic        [REG_ADDR_WIDTH-1:0] addr_q [DEPTH];
    logic        [PW-1:0]             wr_ptr_q, wr_ptr_d;
    logic        [PW-1:0]             rd_ptr_q, rd_ptr_d;
    logic        [CW-1:0]             count_q, count_d;
    logic        [PW-1:0]             scan_idx;

    always_comb begin
        wr_ptr_d = push_i ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_i  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entries are only ever read when occupied, so the array itself needs no reset.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            data_q[wr_ptr_q] <= wdata_i;
            addr_q[wr_ptr_q] <= waddr_i;
        end
    end

    assign rdata_o = data_q[rd_ptr_q];
    assign raddr_o = addr_q[rd_ptr_q];
    assign count_o = count_q;

    // Walk oldest to newest so a later (newer) match overrides an older one.
    always_comb begin
        fwd_hit_o  = 1'b0;
        fwd_data_o = '0;
        scan_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = rd_ptr_q + PW'(i);
            if ((CW'(i) < count_q) && (addr_q[scan_idx] == fwd_addr_i)) begin
                fwd_hit_o  = 1'b1;
                fwd_data_o = data_q[scan_idx];
            end
        end
    end

endmodule

// File: rtl/writeback_queue.sv
// Register-writeback stage: decodes writing opcodes, queues them and presents them to the register file.
module writeback_queue
    import writeback_queue_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 4,
    parameter int CTRL_WIDTH     = 6,
    parameter int DEPTH          = 4,
    parameter int R0_WRITABLE    = 0
) (
    input logic               clk_in,
    input logic               RST,
    writeback_queue_if.slave  bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic        [CTRL_WIDTH-1:0]     ctrl;
    logic        [WBQ_CTRL_W-1:0]     op;
    logic                             wr_dec;
    logic                             push;
    logic                             pop;
    logic                             occupied;
    logic        [CW-1:0]             count_w;
    logic signed [DATA_WIDTH-1:0]     head_data;
    logic        [REG_ADDR_WIDTH-1:0] head_addr;
    logic signed [DATA_WIDTH-1:0]     last_data_q, last_data_d;
    logic        [REG_ADDR_WIDTH-1:0] last_addr_q, last_addr_d;

    assign ctrl   = bus.ctrl_in;
    assign op     = WBQ_CTRL_W'(ctrl);
    assign wr_dec = is_wr(op, (bus.addr == '0), (R0_WRITABLE != 0));

    assign occupied     = (count_w != '0);
    assign bus.in_ready = (count_w < CW'(DEPTH));
    assign push         = bus.in_valid & bus.in_ready & wr_dec;
    assign pop          = occupied & bus.rf_ready;

    wb_fifo_mem #(
        .DATA_WIDTH     (DATA_WIDTH),
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
        .DEPTH          (DEPTH)
    ) u_fifo (
        .clk_i      (clk_in),
        .rst_i      (RST),
        .push_i     (push),
        .pop_i      (pop),
        .wdata_i    (bus.data),
        .waddr_i    (bus.addr),
        .rdata_o    (head_data),
        .raddr_o    (head_addr),
        .count_o    (count_w),
        .fwd_addr_i (bus.fwd_addr),
        .fwd_hit_o  (bus.fwd_hit),
        .fwd_data_o (bus.fwd_data)
    );

    // Once drained, the head outputs keep showing the entry that was last written back.
    always_comb begin
        last_data_d = last_data_q;
        last_addr_d = last_addr_q;
        if (pop) begin
            last_data_d = head_data;
            last_addr_d = head_addr;
        end
    end

    always_ff @(posedge clk_in) begin
        if (RST) begin
            last_data_q <= '0;
            last_addr_q <= '0;
        end else begin
            last_data_q <= last_data_d;
            last_addr_q <= last_addr_d;
        end
    end

    assign bus.en_out   = occupied;
    assign bus.data_out = occupied ? head_data : last_data_q;
    assign bus.addr_out = occupied ? head_addr : last_addr_q;
    assign bus.count    = count_w;

endmodule

// File: tb/tb_writeback_queue.sv
// Directed table-driven bench for writeback_queue plus hand-written forwarding and back-pressure sequences.
module tb_writeback_queue;
    import writeback_queue_pkg::*;

    typedef struct {
        logic               rst;
        logic               vld;
        logic [5:0]         op;
        logic signed [31:0] d;
        logic [3:0]         a;
        logic               rf;
        logic [3:0]         fa;
        logic               rdy;
        logic               en;
        logic signed [31:0] dout;
        logic [3:0]         aout;
        logic [2:0]         cnt;
        logic               hit;
        logic signed [31:0] fd;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    writeback_queue_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(4), .CTRL_WIDTH(6), .DEPTH(4)) bif ();

    writeback_queue #(
        .DATA_WIDTH(32), .REG_ADDR_WIDTH(4), .CTRL_WIDTH(6), .DEPTH(4), .R0_WRITABLE(0)
    ) dut (
        .clk_in (clk),
        .RST    (rst),
        .bus    (bif)
    );

    function automatic vec_t mk(input logic r, input logic v, input opcode_e o, input int d,
                                input int a, input logic rf, input int fa,
                                input logic rdy, input logic en, input int dout, input int aout,
                                input int cnt, input logic hit, input int fd);
        vec_t t;
        t.rst = r;   t.vld = v;   t.op = o;     t.d = d;       t.a = 4'(a);
        t.rf = rf;   t.fa = 4'(fa);
        t.rdy = rdy; t.en = en;   t.dout = dout; t.aout = 4'(aout);
        t.cnt = 3'(cnt); t.hit = hit; t.fd = fd;
        return t;
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [5:0] o, input int d,
                         input int a, input logic rf, input int fa);
        rst          = r;
        bif.in_valid = v;
        bif.ctrl_in  = o;
        bif.data     = d;
        bif.addr     = 4'(a);
        bif.rf_ready = rf;
        bif.fwd_addr = 4'(fa);
    endtask

    initial begin
        drive(1'b1, 1'b0, OP_NOP, 0, 0, 1'b0, 0);

        //           rst  vld  op      d    a   rf  fa   rdy  en   dout  aout cnt hit  fd
        vecs.push_back(mk(1, 0, OP_NOP,  0,  0, 0,  3,   1,   0,   0,    0,   0,  0,   0));
        // single ADD, written back the following cycle
        vecs.push_back(mk(0, 1, OP_ADD,  5,  3, 1,  3,   1,   1,   5,    3,   1,  1,   5));
        vecs.push_back(mk(0, 0, OP_NOP,  0,  0, 1,  3,   1,   0,   5,    3,   0,  0,   0));
        // NOT writes, JMP and ADD-to-r0 are dropped
        vecs.push_back(mk(0, 1, OP_NOT,  7,  2, 1,  2,   1,   1,   7,    2,   1,  1,   7));
        vecs.push_back(mk(0, 1, OP_JMP,  9,  4, 1,  4,   1,   0,   7,    2,   0,  0,   0));
        vecs.push_back(mk(0, 1, OP_ADD,  8,  0, 1,  0,   1,   0,   7,    2,   0,  0,   0));
        vecs.push_back(mk(0, 0, OP_NOP,  0,  0, 1,  0,   1,   0,   7,    2,   0,  0,   0));
        // fill under back-pressure, fifth push ignored, then drain in order
        vecs.push_back(mk(0, 1, OP_ADD,  1,  1, 0,  1,   1,   1,   1,    1,   1,  1,   1));
        vecs.push_back(mk(0, 1, OP_ADD,  2,  2, 0,  2,   1,   1,   1,    1,   2,  1,   2));
        vecs.push_back(mk(0, 1, OP_ADD,  3,  3, 0,  3,   1,   1,   1,    1,   3,  1,   3));
        vecs.push_back(mk(0, 1, OP_ADD,  4,  4, 0,  4,   0,   1,   1,    1,   4,  1,   4));
        vecs.push_back(mk(0, 1, OP_ADD, 55,  5, 0,  5,   0,   1,   1,    1,   4,  0,   0));
        vecs.push_back(mk(0, 0, OP_NOP,  0,  0, 1,  1,   1,   1,   2,    2,   3,  0,   0));
        vecs.push_back(mk(0, 0, OP_NOP,  0,  0, 1,  0,   1,   1,   3,    3,   2,  0,   0));
        vecs.push_back(mk(0, 0, OP_NOP,  0,  0, 1,  4,   1,   1,   4,    4,   1,  1,   4));
        vecs.push_back(mk(0, 0, OP_NOP,  0,  0, 1,  4,   1,   0,   4,    4,   0,  0,   0));
        // forwarding returns the newest of two writes to r5
        vecs.push_back(mk(0, 1, OP_ADD, 10,  5, 0,  5,   1,   1,  10,    5,   1,  1,  10));
        vecs.push_back(mk(0, 1, OP_ADD, -7,  5, 0,  5,   1,   1,  10,    5,   2,  1,  -7));
        vecs.push_back(mk(0, 0, OP_NOP,  0,  0, 0,  6,   1,   1,  10,    5,   2,  0,   0));
        vecs.push_back(mk(0, 0, OP_NOP,  0,  0, 0,  5,   1,   1,  10,    5,   2,  1,  -7));
        // full with push+pop: push rejected; then steady push+pop wraps pointers
        vecs.push_back(mk(0, 1, OP_ADD, 70,  7, 0,  7,   1,   1,  10,    5,   3,  1,  70));
        vecs.push_back(mk(0, 1, OP_ADD, 80,  8, 0,  8,   0,   1,  10,    5,   4,  1,  80));
        vecs.push_back(mk(0, 1, OP_ADD, 90,  9, 1,  9,   1,   1,  -7,    5,   3,  0,   0));
        vecs.push_back(mk(0, 1, OP_ADD, 90,  9, 1,  9,   1,   1,  70,    7,   3,  1,  90));
        vecs.push_back(mk(0, 0, OP_NOP,  0,  0, 1,  7,   1,   1,  80,    8,   2,  0,   0));
        vecs.push_back(mk(0, 1, OP_SUB,100, 10, 1, 10,   1,   1,  90,    9,   2,  1, 100));
        vecs.push_back(mk(0, 1, OP_MUL,110, 11, 1,  9,   1,   1, 100,   10,   2,  0,   0));
        vecs.push_back(mk(0, 1, OP_AND, -1, 12, 1, 12,   1,   1, 110,   11,   2,  1,  -1));
        vecs.push_back(mk(0, 1, OP_LW,  13, 13, 1, 13,   1,   1,  -1,   12,   2,  1,  13));
        vecs.push_back(mk(0, 0, OP_NOP,  0,  0, 1, 13,   1,   1,  13,   13,   1,  1,  13));
        vecs.push_back(mk(0, 0, OP_NOP,  0,  0, 1, 13,   1,   0,  13,   13,   0,  0,   0));
        // reset with three entries queued and push+pop active
        vecs.push_back(mk(0, 1, OP_ADD,  1,  1, 0,  1,   1,   1,   1,    1,   1,  1,   1));
        vecs.push_back(mk(0, 1, OP_ADD,  2,  2, 0,  1,   1,   1,   1,    1,   2,  1,   1));
        vecs.push_back(mk(0, 1, OP_ADD,  3,  3, 0,  1,   1,   1,   1,    1,   3,  1,   1));
        vecs.push_back(mk(1, 1, OP_ADD,  4,  4, 1,  1,   1,   0,   0,    0,   0,  0,   0));
        vecs.push_back(mk(0, 0, OP_NOP,  0,  0, 1,  1,   1,   0,   0,    0,   0,  0,   0));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].vld, vecs[i].op, vecs[i].d, int'(vecs[i].a),
                  vecs[i].rf, int'(vecs[i].fa));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d.in_ready", i), longint'(bif.in_ready), longint'(vecs[i].rdy));
            chk($sformatf("v%0d.en_out", i),   longint'(bif.en_out),   longint'(vecs[i].en));
            chk($sformatf("v%0d.count", i),    longint'(bif.count),    longint'(vecs[i].cnt));
            chk($sformatf("v%0d.fwd_hit", i),  longint'(bif.fwd_hit),  longint'(vecs[i].hit));
            chk($sformatf("v%0d.fwd_data", i), longint'(bif.fwd_data), longint'(vecs[i].fd));
            if (vecs[i].en || vecs[i].rst) begin
                chk($sformatf("v%0d.data_out", i), longint'(bif.data_out), longint'(vecs[i].dout));
                chk($sformatf("v%0d.addr_out", i), longint'(bif.addr_out), longint'(vecs[i].aout));
            end
        end

        // Entry being pushed is invisible this cycle; no bypass to en_out either.
        drive(1'b0, 1'b1, OP_ADD, 20, 6, 1'b0, 6);
        #1;
        chk("seqA.pre_push_hit", longint'(bif.fwd_hit), 0);
        chk("seqA.pre_push_en",  longint'(bif.en_out),  0);
        @(posedge clk);
        #1;
        chk("seqA.post_push_en",   longint'(bif.en_out),   1);
        chk("seqA.post_push_hit",  longint'(bif.fwd_hit),  1);
        chk("seqA.post_push_data", longint'(bif.fwd_data), 20);
        // Head being popped stays visible to forwarding until the edge.
        drive(1'b0, 1'b0, OP_NOP, 0, 0, 1'b1, 6);
        #1;
        chk("seqA.popping_hit",  longint'(bif.fwd_hit),  1);
        chk("seqA.popping_data", longint'(bif.fwd_data), 20);
        @(posedge clk);
        #1;
        chk("seqA.popped_count", longint'(bif.count),    0);
        chk("seqA.popped_hit",   longint'(bif.fwd_hit),  0);
        chk("seqA.held_data",    longint'(bif.data_out), 20);

        // in_ready stays low while full even with rf_ready raised.
        for (int k = 1; k <= 4; k++) begin
            drive(1'b0, 1'b1, OP_DIV, k * 11, k, 1'b0, 0);
            @(posedge clk);
            #1;
        end
        chk("seqB.full_count", longint'(bif.count), 4);
        drive(1'b0, 1'b0, OP_NOP, 0, 0, 1'b1, 0);
        #1;
        chk("seqB.full_ready_rf1", longint'(bif.in_ready), 0);
        chk("seqB.head_data",      longint'(bif.data_out), 11);
        @(posedge clk);
        #1;
        chk("seqB.freed_ready", longint'(bif.in_ready), 1);
        chk("seqB.next_head",   longint'(bif.data_out), 22);

        drive(1'b1, 1'b0, OP_NOP, 0, 0, 1'b0, 0);
        @(posedge clk);
        #1;
        chk("seqB.reset_count", longint'(bif.count), 0);
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/writeback_queue.md
Name: writeback_queue

Overview:
- Parametrised register-writeback stage that follows the pipeline's final stage.
- Decodes the opcode to decide whether the register file is written, and drops non-writing instructions.
- Buffers pending writes in a DEPTH-entry FIFO so the register-file write port may back-pressure.
- Exposes a forwarding lookup so earlier stages can read the newest pending value for a register.

Parameters:
- DATA_WIDTH, 32: width of writeback data (signed).
- REG_ADDR_WIDTH, 4: register address width.
- CTRL_WIDTH, 6: opcode width; opcode values come from params_proc.v.
- DEPTH, 4: FIFO entries; power of two, at least 2.
- R0_WRITABLE, 0: 0 means writes to address 0 are discarded; 1 means they are kept.

Ports:
- clk_in  in  1  the single clock.
- RST  in  1  synchronous, active-high reset.
- in_valid  in  1  an instruction is presented.
- in_ready  out  1  the queue can accept an instruction.
- ctrl_in  in  CTRL_WIDTH  opcode.
- data  in  DATA_WIDTH  result value.
- addr  in  REG_ADDR_WIDTH  destination register.
- rf_ready  in  1  the register file accepts the write this cycle.
- en_out  out  1  a write is pending at the head.
- data_out  out  DATA_WIDTH  head data.
- addr_out  out  REG_ADDR_WIDTH  head address.
- fwd_addr  in  REG_ADDR_WIDTH  forwarding query address.
- fwd_hit  out  1  a queued entry matches fwd_addr.
- fwd_data  out  DATA_WIDTH  newest matching queued data.
- count  out  clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Reset: synchronous, active-high, sampled on posedge clk_in.
  - Clears wr_ptr, rd_ptr and count.
  - en_out=0, data_out=0, addr_out=0; fwd_hit=0 for every query.
  - Reset overrides a push or pop in the same cycle.
  - Reset mid-operation discards all queued entries.
- Write decode (combinational, is_wr):
  - 1 for LW, LW_IMM, ADD, SUB, MUL, DIV, AND, OR, NOT.
  - 0 for every other opcode, including control transfer.
  - Forced to 0 when addr==0 and R0_WRITABLE==0.
- in_ready = (count < DEPTH). It is a pure function of registered count and has no combinational path from rf_ready.
- Accept = in_valid & in_ready.
  - Push = accept & is_wr.
  - Accepted non-writing instructions are consumed and discarded; count is unchanged.
- Pop = en_out & rf_ready.
- Outputs:
  - en_out = (count != 0).
  - data_out/addr_out = storage[rd_ptr]; they hold their value while rf_ready=0.
  - When the queue is empty, data_out/addr_out hold the last head value (don't-care to consumers).
- Latency: a push into an empty queue at edge N asserts en_out after edge N, with the entry visible in that same cycle. There is no same-cycle bypass from input to output.
- Simultaneous push and pop: legal whenever in_ready=1; count is unchanged and both pointers advance.
- Full: in_ready=0, so no push is possible. A pop in the full cycle frees a slot that is visible the next cycle.
- Empty: pop cannot occur because en_out=0.
- Pointers wrap modulo DEPTH.
- Forwarding (combinational):
  - Scan the occupied entries from newest (wr_ptr-1) to oldest (rd_ptr).
  - fwd_hit=1 on the first address match, and fwd_data takes that entry's data.
  - With no match: fwd_hit=0, fwd_data=0.
  - The entry being pushed this cycle is not visible until the next cycle.
  - The head being popped this cycle remains visible in this cycle.
- Arithmetic: data passes through unmodified; signedness is preserved.
- Ordering: strict FIFO; register-file writes occur in issue order.

Decomposition:
- Opcode constants and widths (CTRL_WIDTH, DATA_WIDTH, REG_ADDR_WIDTH) remain in the shared params_proc.v include.
- Add is_wr as a shared function in that include so other stages reuse the same decode.
- One natural sub-module, wb_fifo_mem: the storage array plus pointer/count logic, including the forwarding scan.
- writeback_queue wraps wb_fifo_mem with decode, handshake and outputs.

Test Plan:
- Reset, then stream ADD r3=5 with rf_ready=1 -> en_out=1 one cycle later with addr_out=3, data_out=5; count returns to 0 the cycle after.
- Stream of NOT, then a control-transfer opcode, then ADD to addr=0, with R0_WRITABLE=0 -> only NOT produces en_out; count never exceeds 1.
- rf_ready=0; push ADD r1=1, r2=2, r3=3, r4=4 -> count=4, in_ready=0; a fifth push is ignored. Raise rf_ready -> outputs 1,2,3,4 on consecutive cycles in order.
- Push r5=10, then r5=-7, with rf_ready=0; fwd_addr=5 -> fwd_hit=1, fwd_data=-7. fwd_addr=6 -> fwd_hit=0, fwd_data=0.
- Full queue with push and pop in the same cycle -> push rejected (in_ready=0), count becomes 3. Steady push+pop at count=2 -> count stays 2 and pointers wrap past DEPTH correctly.
- Assert RST with 3 entries queued and push+pop active -> next cycle count=0, en_out=0, data_out=0, addr_out=0, fwd_hit=0.
